// File: rtl/serial_parity_checker_pkg.sv
// rtl/serial_parity_checker_pkg.sv - shared types and constants for the serial parity checker
//
// Purpose : frame FSM state encoding and the default frame width used by
//           serial_parity_checker and its testbench.
// Ports   : none (package).

package serial_parity_checker_pkg;

   localparam int DEFAULT_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage : serial_parity_checker_pkg

// File: rtl/serial_parity_checker_parity_acc.sv
// rtl/serial_parity_checker_parity_acc.sv - running XOR accumulator over accepted data bits
//
// Purpose : keeps the XOR of every data bit accepted in the current frame.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears acc
//           clr   - synchronous clear at frame start (wins over en)
//           en    - fold d into the accumulator this cycle
//           d     - serial data bit
//           acc   - accumulated XOR

module parity_acc (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic d,
   output logic acc
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= 1'b0;
      end else if (clr) begin
         acc <= 1'b0;
      end else if (en) begin
         acc <= acc ^ d;
      end
   end

endmodule : parity_acc

// File: rtl/serial_parity_checker.sv
// rtl/serial_parity_checker.sv - serial frame receiver with data capture and parity check
//
// Purpose : receives a frame of DATA_W data bits (LSB first) followed by one
//           parity bit, then presents the data and the parity result with a
//           one-cycle out_valid pulse.
// Ports   : clk        - rising-edge clock
//           rst_n      - asynchronous active-low reset
//           start      - frame-start strobe, honoured only in IDLE
//           bit_in     - serial data / parity bit
//           bit_valid  - bit_in qualifier
//           busy       - frame in progress (DATA or PARITY)
//           data_out   - data bits of the last completed frame
//           out_valid  - one-cycle completion pulse
//           parity_err - parity result of the last completed frame

module serial_parity_checker
   import serial_parity_checker_pkg::*;
#(
   parameter int DATA_W     = DEFAULT_DATA_W,
   parameter int ODD_PARITY = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              bit_in,
   input  logic              bit_valid,
   output logic              busy,
   output logic [DATA_W-1:0] data_out,
   output logic              out_valid,
   output logic              parity_err
);

   localparam int              CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
   localparam logic             ODD_BIT  = (ODD_PARITY != 0);

   state_t              state_q;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   shift_reg;
   logic                acc;

   logic                frame_start;
   logic                data_take;
   logic                parity_take;

   // Next-state and per-cycle strobes
   always_comb begin
      state_nxt   = state_q;
      frame_start = 1'b0;
      data_take   = 1'b0;
      parity_take = 1'b0;
      unique case (state_q)
         IDLE: begin
            // a bit_valid arriving with start is deliberately not captured
            if (start) begin
               frame_start = 1'b1;
               state_nxt   = DATA;
            end
         end
         DATA: begin
            if (bit_valid) begin
               data_take = 1'b1;
               if (cnt_q == LAST_IDX) begin
                  state_nxt = PARITY;
               end
            end
         end
         PARITY: begin
            if (bit_valid) begin
               parity_take = 1'b1;
               state_nxt   = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_nxt;
      end
   end

   parity_acc u_parity_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (frame_start),
      .en    (data_take),
      .d     (bit_in),
      .acc   (acc)
   );

   // Bit counter, shift register and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         shift_reg  <= '0;
         data_out   <= '0;
         parity_err <= 1'b0;
      end else begin
         if (frame_start) begin
            cnt_q <= '0;
         end else if (data_take) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end

         // decoded write avoids indexing DATA_W bits with a wider counter
         if (data_take) begin
            for (int i = 0; i < DATA_W; i++) begin
               if (cnt_q == CNT_W'(i)) begin
                  shift_reg[i] <= bit_in;
               end
            end
         end

         if (parity_take) begin
            data_out   <= shift_reg;
            parity_err <= acc ^ bit_in ^ ODD_BIT;
         end
      end
   end

   // Pure state decodes: no input reaches an output combinationally
   assign busy      = (state_q == DATA) || (state_q == PARITY);
   assign out_valid = (state_q == DONE);

endmodule : serial_parity_checker

// File: doc/serial_parity_checker.md
SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_W, default 8, is the number of data bits per frame (legal range 2..32).
REQ-002 Parameter ODD_PARITY, default 0, selects the parity sense: 0 = even, 1 = odd.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 Port start  input  1  frame-start strobe, sampled only in IDLE.
REQ-006 Port bit_in  input  1  serial data or parity bit, qualified by bit_valid.
REQ-007 Port bit_valid  input  1  bit_in carries a valid bit this cycle.
REQ-008 Port busy  output  1  high while a frame is in progress (states DATA and PARITY).
REQ-009 Port data_out  output  DATA_W  last completed frame, data bits only.
REQ-010 Port out_valid  output  1  one-cycle pulse marking a completed frame.
REQ-011 Port parity_err  output  1  parity result of the last frame, valid with out_valid and held after it.

Function
REQ-012 The FSM SHALL have four states: IDLE, DATA, PARITY and DONE.
REQ-013 IDLE: start=1 -> DATA, bit counter cleared to 0, parity accumulator cleared to 0; bit_valid in IDLE is ignored.
REQ-014 start=1 and bit_valid=1 in the same IDLE cycle: the FSM enters DATA and that bit is not captured.
REQ-015 DATA, bit_valid=1: bit_in is written to shift_reg[cnt] (LSB first), acc <= acc ^ bit_in, cnt increments by 1.
REQ-016 DATA, bit_valid=0: cnt, acc and shift_reg all hold; gaps of any length are legal.
REQ-017 DATA: the cycle that accepts bit DATA_W-1 moves the FSM to PARITY.
REQ-018 PARITY, bit_valid=1: parity_err is registered as acc ^ bit_in ^ ODD_PARITY, shift_reg is copied to data_out, and the FSM moves to DONE.
REQ-019 PARITY, bit_valid=0: the FSM holds in PARITY.
REQ-020 DONE: out_valid=1 for exactly this one cycle, then the FSM moves unconditionally to IDLE.
REQ-021 Latency: out_valid rises in the cycle after the parity bit is accepted.
REQ-022 start outside IDLE SHALL be ignored and SHALL NOT restart the frame; this includes DONE.
REQ-023 data_out and parity_err SHALL hold their values until the next DONE.
REQ-024 cnt width SHALL be $clog2(DATA_W+1) bits; cnt never wraps within a frame.
REQ-025 busy = (state==DATA) || (state==PARITY), registered-state decode with no input paths.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, cnt=0, acc=0, shift_reg=0, data_out=0, parity_err=0, out_valid=0, busy=0.
REQ-027 Reset mid-frame discards the partial frame and produces no out_valid.
REQ-028 After rst_n deasserts, the first rising edge of clk SHALL accept start normally.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE, DATA, PARITY, DONE) and the default DATA_W constant.
REQ-030 The running XOR SHALL be a sub-module parity_acc (ports: clk, rst_n, clr, en, d, acc); the FSM, counter and shift register stay in the top module.
REQ-031 There SHALL be no combinational path from any input to any output.

Verification
REQ-032 Even parity, DATA_W=8: start, then bits 1,0,1,0,0,1,0,1 (8'hA5), then parity 0 -> data_out=8'hA5, parity_err=0, out_valid one cycle.
REQ-033 Even parity: the same 8'hA5 frame with parity bit 1 -> parity_err=1, data_out=8'hA5.
REQ-034 ODD_PARITY=1: frame 8'h01 with parity bit 0 -> parity_err=0; the same frame with parity bit 1 -> parity_err=1.
REQ-035 bit_valid gaps of 3 idle cycles between bits, plus start pulsed mid-frame -> result identical to REQ-032 and no restart.
REQ-036 rst_n low after the 4th data bit, then a full 8'h3C frame with parity 0 -> a single out_valid, data_out=8'h3C, parity_err=0, and no output from the aborted frame.
